// File: rtl/cdecv_ctrl_pkg.sv
// Shared definitions for the CDECV execution controller.
// Holds the command opcode encoding, the controller state encoding and
// the width of the pulse/step counter. Imported by the controller top,
// its strobe generator and the command/response interface.
package cdecv_ctrl_pkg;

  // Pulse/step counter must hold 256 (a STEP with count 0)
  localparam int STEP_CNT_W = 9;

  // Command opcodes carried on cmd_op; 5..7 are illegal
  typedef enum logic [2:0] {
    OP_MWR  = 3'd0,
    OP_MRD  = 3'd1,
    OP_STEP = 3'd2,
    OP_CRST = 3'd3,
    OP_DRD  = 3'd4
  } op_t;

  // Controller states
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_MEM_HI,
    ST_MEM_LO,
    ST_STEP_HI,
    ST_STEP_LO,
    ST_RST_HI,
    ST_RST_LO,
    ST_DBG_WAIT,
    ST_RSP
  } state_t;

endpackage

// File: rtl/cdecv_exec_ctrl_if.sv
// Command/response channel between the monitor command path and the
// CDECV execution controller.
//   cmd_valid/cmd_ready : command handshake
//   cmd_op/addr/data    : opcode, address (or debug index), data (or step count)
//   rsp_valid/rsp_ready : response handshake
//   rsp_data/rsp_err    : read result and illegal-opcode flag
// master = command issuer (monitor side), slave = the controller.
interface cdecv_exec_ctrl_if;
  import cdecv_ctrl_pkg::*;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/cdecv_exec_ctrl_strobe_gen.sv
// Single-pulse strobe generator for the CDECV execution controller.
// A start request produces one strobe period: HALF cycles high followed by
// HALF cycles low. A start arriving on the last low cycle chains straight
// into the next pulse with no gap.
//   clk, rst : system clock, synchronous active-high reset
//   start    : begin a new pulse (strobe high from the next cycle)
//   strobe   : registered strobe output
//   last_hi  : current cycle is the final high cycle
//   done     : current cycle is the final low cycle
module cdecv_exec_ctrl_strobe_gen #(
  parameter int unsigned HALF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic strobe,
  output logic last_hi,
  output logic done
);
  import cdecv_ctrl_pkg::*;

  localparam int unsigned CW = $clog2(HALF + 1);
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt;
  logic          busy;

  // Phase counter: counts cycles within the current half-period; the
  // strobe level itself tells which half we are in.
  always_ff @(posedge clk) begin
    if (rst) begin
      strobe <= 1'b0;
      busy   <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      strobe <= 1'b1;
      busy   <= 1'b1;
      cnt    <= '0;
    end else if (busy) begin
      if (cnt == LAST) begin
        cnt <= '0;
        if (strobe) strobe <= 1'b0;
        else        busy   <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign last_hi = busy && strobe && (cnt == LAST);
  assign done    = busy && !strobe && (cnt == LAST);

endmodule

// File: rtl/cdecv_exec_ctrl.sv
// CDECV execution controller: runs one monitor command at a time
// (memory write/read, N-cycle single step, CDECV reset sequence, debug
// register read) and returns exactly one response per command.
//   clk_clk, reset_reset : system clock, synchronous active-high reset
//   bus                  : command/response channel (slave side)
//   prg_ma/wd/we/clock   : program memory address, write data, write enable, clock strobe
//   prg_rd               : program memory read data
//   clock_to_cdecv       : CDECV clock strobe
//   reset_to_cdecv       : CDECV reset
//   dbg_addr/dbg_data    : debug register select and value
module cdecv_exec_ctrl #(
  parameter int unsigned HALF       = 2,
  parameter int unsigned RST_PULSES = 2,
  parameter int unsigned DBG_WAIT   = 2
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset,
  cdecv_exec_ctrl_if.slave        bus,
  output logic [7:0]              prg_ma,
  output logic [7:0]              prg_wd,
  output logic                    prg_we,
  output logic                    prg_clock,
  input  logic [7:0]              prg_rd,
  output logic                    clock_to_cdecv,
  output logic                    reset_to_cdecv,
  output logic [3:0]              dbg_addr,
  input  logic [15:0]             dbg_data
);
  import cdecv_ctrl_pkg::*;

  state_t                  state;
  logic [STEP_CNT_W-1:0]   pulse_cnt;
  logic [STEP_CNT_W-1:0]   step_total;
  logic                    accept;
  logic                    sg_start;
  logic                    sg_strobe;
  logic                    sg_last_hi;
  logic                    sg_done;

  assign accept = bus.cmd_valid && bus.cmd_ready;

  // Start a strobe pulse on acceptance of a strobing command, and chain the
  // next pulse on the last low cycle while more pulses remain.
  always_comb begin
    sg_start = 1'b0;
    if (state == ST_IDLE && accept) begin
      sg_start = bus.cmd_op inside {OP_MWR, OP_MRD, OP_STEP, OP_CRST};
    end else if ((state == ST_STEP_LO || state == ST_RST_LO) && sg_done &&
                 pulse_cnt > STEP_CNT_W'(1)) begin
      sg_start = 1'b1;
    end
  end

  cdecv_exec_ctrl_strobe_gen #(.HALF(HALF)) strobe_gen (
    .clk     (clk_clk),
    .rst     (reset_redirect_guard()),
    .start   (sg_start),
    .strobe  (sg_strobe),
    .last_hi (sg_last_hi),
    .done    (sg_done)
  );

  function automatic logic reset_redirect_guard();
    return reset_reset;
  endfunction

  // The single strobe is steered to whichever target the state owns, so the
  // two strobes can never be high together.
  assign prg_clock      = sg_strobe && (state == ST_MEM_HI);
  assign clock_to_cdecv = sg_strobe && (state == ST_STEP_HI || state == ST_RST_HI);

  // Command sequencer. One pulse counter is shared by STEP (remaining
  // pulses), CRST (remaining reset pulses) and DRD (remaining wait cycles).
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state          <= ST_IDLE;
      bus.cmd_ready  <= 1'b1;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_data   <= '0;
      bus.rsp_err    <= 1'b0;
      prg_ma         <= '0;
      prg_wd         <= '0;
      prg_we         <= 1'b0;
      reset_to_cdecv <= 1'b0;
      dbg_addr       <= '0;
      pulse_cnt      <= '0;
      step_total     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            bus.cmd_ready <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
            case (op_t'(bus.cmd_op))
              OP_MWR: begin
                prg_ma <= bus.cmd_addr;
                prg_wd <= bus.cmd_data;
                prg_we <= 1'b1;
                state  <= ST_MEM_HI;
              end
              OP_MRD: begin
                prg_ma <= bus.cmd_addr;
                prg_we <= 1'b0;
                state  <= ST_MEM_HI;
              end
              OP_STEP: begin
                // A count of 0 means a full 256 pulses
                pulse_cnt  <= (bus.cmd_data == 8'd0) ? STEP_CNT_W'(256)
                                                     : {1'b0, bus.cmd_data};
                step_total <= (bus.cmd_data == 8'd0) ? STEP_CNT_W'(256)
                                                     : {1'b0, bus.cmd_data};
                state      <= ST_STEP_HI;
              end
              OP_CRST: begin
                reset_to_cdecv <= 1'b1;
                pulse_cnt      <= STEP_CNT_W'(RST_PULSES);
                state          <= ST_RST_HI;
              end
              OP_DRD: begin
                dbg_addr  <= bus.cmd_addr[3:0];
                pulse_cnt <= STEP_CNT_W'(DBG_WAIT);
                state     <= ST_DBG_WAIT;
              end
              default: begin
                bus.rsp_err   <= 1'b1;
                bus.rsp_valid <= 1'b1;
                state         <= ST_RSP;
              end
            endcase
          end
        end
        ST_MEM_HI: begin
          if (sg_last_hi) begin
            // Reads capture memory data while the memory clock is still high
            if (!prg_we) bus.rsp_data <= {8'h00, prg_rd};
            state <= ST_MEM_LO;
          end
        end
        ST_MEM_LO: begin
          if (sg_done) begin
            prg_we        <= 1'b0;
            bus.rsp_valid <= 1'b1;
            state         <= ST_RSP;
          end
        end
        ST_STEP_HI: begin
          if (sg_last_hi) state <= ST_STEP_LO;
        end
        ST_STEP_LO: begin
          if (sg_done) begin
            if (pulse_cnt > STEP_CNT_W'(1)) begin
              pulse_cnt <= pulse_cnt - 1'b1;
              state     <= ST_STEP_HI;
            end else begin
              pulse_cnt     <= '0;
              bus.rsp_data  <= {7'd0, step_total};
              bus.rsp_valid <= 1'b1;
              state         <= ST_RSP;
            end
          end
        end
        ST_RST_HI: begin
          if (sg_last_hi) state <= ST_RST_LO;
        end
        ST_RST_LO: begin
          if (sg_done) begin
            if (pulse_cnt > STEP_CNT_W'(1)) begin
              pulse_cnt <= pulse_cnt - 1'b1;
              state     <= ST_RST_HI;
            end else begin
              pulse_cnt      <= '0;
              reset_to_cdecv <= 1'b0;
              bus.rsp_valid  <= 1'b1;
              state          <= ST_RSP;
            end
          end
        end
        ST_DBG_WAIT: begin
          if (pulse_cnt <= STEP_CNT_W'(1)) begin
            pulse_cnt     <= '0;
            bus.rsp_data  <= dbg_data;
            bus.rsp_valid <= 1'b1;
            state         <= ST_RSP;
          end else begin
            pulse_cnt <= pulse_cnt - 1'b1;
          end
        end
        ST_RSP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdecv_exec_ctrl.sv
// Testbench for cdecv_exec_ctrl: directed commands with hand-computed
// expected responses queued in a scoreboard, popped by a monitor on each
// response handshake. Side monitors watch strobe shapes and memory signals.
module tb_cdecv_exec_ctrl;
  import cdecv_ctrl_pkg::*;

  localparam int HALF       = 2;
  localparam int RST_PULSES = 2;
  localparam int DBG_WAIT   = 2;

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic [7:0]  prg_ma, prg_wd, prg_rd;
  logic        prg_we, prg_clock, clock_to_cdecv, reset_to_cdecv;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [7:0]  mem [256];

  cdecv_exec_ctrl_if bus();

  cdecv_exec_ctrl #(.HALF(HALF), .RST_PULSES(RST_PULSES), .DBG_WAIT(DBG_WAIT)) dut (
    .clk_clk        (clk_clk),
    .reset_reset    (reset_reset),
    .bus            (bus),
    .prg_ma         (prg_ma),
    .prg_wd         (prg_wd),
    .prg_we         (prg_we),
    .prg_clock      (prg_clock),
    .prg_rd         (prg_rd),
    .clock_to_cdecv (clock_to_cdecv),
    .reset_to_cdecv (reset_to_cdecv),
    .dbg_addr       (dbg_addr),
    .dbg_data       (dbg_data)
  );

  always #5 clk_clk = ~clk_clk;

  // External program memory and debug register file models
  always @(posedge prg_clock) if (prg_we) mem[prg_ma] <= prg_wd;
  assign prg_rd   = mem[prg_ma];
  assign dbg_data = (dbg_addr == 4'h7) ? 16'hBEEF : {dbg_addr, 12'hACE};

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  bit          lat_pending = 0;
  int          run_p = 0, run_c = 0;
  bit          rst_prev = 1;
  int          ctc_pulses = 0, rst_pulses = 0;
  bit          we_seen = 0;
  logic        rtc_at_rsp = 1'b0;
  logic [7:0]  ma_at_clk = '0, wd_at_clk = '0;
  logic        we_at_clk = 1'b0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  always @(posedge clk_clk) cyc <= cyc + 1;

  always @(posedge clock_to_cdecv) begin
    ctc_pulses++;
    if (reset_to_cdecv) rst_pulses++;
  end

  always @(posedge prg_clock) begin
    ma_at_clk = prg_ma;
    wd_at_clk = prg_wd;
    we_at_clk = prg_we;
  end

  // Response monitor and strobe-shape monitor, sampling just after the
  // falling edge where stimulus has already settled.
  always @(negedge clk_clk) begin
    exp_t e;
    #1;
    if (!reset_reset) begin
      if (bus.cmd_valid && bus.cmd_ready) begin
        accept_cyc  = cyc;
        lat_pending = 1;
      end
      if (bus.rsp_valid && lat_pending) begin
        lat_pending = 0;
        rtc_at_rsp  = reset_to_cdecv;
        if (sb.size() > 0) checkOutput("latency", cyc - accept_cyc, sb[0].lat);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_rsp: got data 0x%0h, required no response", bus.rsp_data);
        end else begin
          e = sb.pop_front();
          checkOutput("rsp_data", bus.rsp_data, e.data);
          checkOutput("rsp_err", bus.rsp_err, e.err);
        end
      end
      if (prg_we) we_seen = 1;
    end
    if (prg_clock) run_p++;
    else begin
      if (run_p > 0 && !rst_prev) checkOutput("prg_clock_high_len", run_p, HALF);
      run_p = 0;
    end
    if (clock_to_cdecv) run_c++;
    else begin
      if (run_c > 0 && !rst_prev) checkOutput("cdecv_clock_high_len", run_c, HALF);
      run_c = 0;
    end
    if (prg_clock || clock_to_cdecv)
      checkOutput("strobe_overlap", {1'b0, prg_clock && clock_to_cdecv}, 0);
    rst_prev = reset_reset;
  end

  // Issue one command (caller is at a falling edge) and queue its response
  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] addr, input logic [7:0] data,
                               input logic [15:0] exp_data, input logic exp_err, input int exp_lat);
    exp_t e;
    int   n = 0;
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk_clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      checks++;
      $display("[TB] FAIL cmd_ready_timeout: got 0, required 1");
    end
    e.data = exp_data;
    e.err  = exp_err;
    e.lat  = exp_lat;
    sb.push_back(e);
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    @(negedge clk_clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd7;
    bus.cmd_addr  = ~addr;
    bus.cmd_data  = ~data;
  endtask

  task automatic waitIdle(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk_clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      $display("[TB] FAIL rsp_timeout: got no response in %0d cycles, required %0d pending", limit, sb.size());
      sb.delete();
    end
    @(negedge clk_clk);
  endtask

  initial begin
    int base;
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    repeat (3) @(negedge clk_clk);
    checkOutput("reset_cmd_ready", bus.cmd_ready, 1);
    checkOutput("reset_rsp_valid", bus.rsp_valid, 0);
    checkOutput("reset_rsp_data", bus.rsp_data, 0);
    checkOutput("reset_prg_we", prg_we, 0);
    checkOutput("reset_prg_clock", prg_clock, 0);
    checkOutput("reset_clock_to_cdecv", clock_to_cdecv, 0);
    checkOutput("reset_reset_to_cdecv", reset_to_cdecv, 0);
    checkOutput("reset_dbg_addr", dbg_addr, 0);
    reset_reset = 1'b0;
    @(negedge clk_clk);

    $display("[TB] MWR / MRD");
    applyStimulus(OP_MWR, 8'h3C, 8'hA5, 16'h0000, 1'b0, 5);
    waitIdle(50);
    checkOutput("mwr_prg_ma", ma_at_clk, 8'h3C);
    checkOutput("mwr_prg_wd", wd_at_clk, 8'hA5);
    checkOutput("mwr_prg_we", we_at_clk, 1);
    checkOutput("mwr_we_dropped", prg_we, 0);
    we_seen = 0;
    applyStimulus(OP_MRD, 8'h3C, 8'h00, 16'h00A5, 1'b0, 5);
    waitIdle(50);
    checkOutput("mrd_we_low", we_seen, 0);
    applyStimulus(OP_MWR, 8'h3C, 8'h5A, 16'h0000, 1'b0, 5);
    waitIdle(50);
    applyStimulus(OP_MRD, 8'h3C, 8'h00, 16'h005A, 1'b0, 5);
    waitIdle(50);

    $display("[TB] STEP");
    base = ctc_pulses;
    applyStimulus(OP_STEP, 8'h00, 8'd0, 16'h0100, 1'b0, 1025);
    waitIdle(2000);
    checkOutput("step256_pulses", ctc_pulses - base, 256);
    base = ctc_pulses;
    applyStimulus(OP_STEP, 8'h00, 8'd3, 16'h0003, 1'b0, 13);
    waitIdle(100);
    checkOutput("step3_pulses", ctc_pulses - base, 3);

    $display("[TB] CRST");
    base = ctc_pulses;
    rst_pulses = 0;
    applyStimulus(OP_CRST, 8'h00, 8'h00, 16'h0000, 1'b0, 9);
    waitIdle(100);
    checkOutput("crst_pulses_in_reset", rst_pulses, 2);
    checkOutput("crst_total_pulses", ctc_pulses - base, 2);
    checkOutput("crst_reset_at_rsp", rtc_at_rsp, 0);

    $display("[TB] DRD / illegal");
    applyStimulus(OP_DRD, 8'h07, 8'h00, 16'hBEEF, 1'b0, 3);
    waitIdle(50);
    checkOutput("drd_dbg_addr", dbg_addr, 4'h7);
    applyStimulus(3'd6, 8'h12, 8'h34, 16'h0000, 1'b1, 1);
    waitIdle(50);

    $display("[TB] back-pressure");
    bus.rsp_ready = 1'b0;
    applyStimulus(OP_DRD, 8'h02, 8'h00, 16'h2ACE, 1'b0, 3);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk_clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_rsp_valid", bus.rsp_valid, 1);
      checkOutput("bp_rsp_data", bus.rsp_data, 16'h2ACE);
      checkOutput("bp_cmd_ready", bus.cmd_ready, 0);
      @(negedge clk_clk);
    end
    bus.rsp_ready = 1'b1;
    waitIdle(50);

    $display("[TB] reset during STEP");
    base = ctc_pulses;
    applyStimulus(OP_STEP, 8'h00, 8'd200, 16'd200, 1'b0, 801);
    n = 0;
    while (ctc_pulses - base < 50 && n < 1000) begin
      @(negedge clk_clk);
      n++;
    end
    checkOutput("abort_reached_pulse50", ctc_pulses - base, 50);
    reset_reset = 1'b1;
    @(negedge clk_clk);
    reset_reset = 1'b0;
    sb.delete();
    lat_pending = 0;
    checkOutput("abort_prg_clock", prg_clock, 0);
    checkOutput("abort_clock_to_cdecv", clock_to_cdecv, 0);
    checkOutput("abort_reset_to_cdecv", reset_to_cdecv, 0);
    checkOutput("abort_cmd_ready", bus.cmd_ready, 1);
    checkOutput("abort_rsp_valid", bus.rsp_valid, 0);
    @(negedge clk_clk);
    applyStimulus(OP_MWR, 8'h10, 8'h77, 16'h0000, 1'b0, 5);
    waitIdle(50);
    applyStimulus(OP_MRD, 8'h10, 8'h00, 16'h0077, 1'b0, 5);
    waitIdle(50);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
